// File: rtl/clk_gate_pkg.sv
// Shared state encodings for the clock-gate enable controller.
package clk_gate_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/clk_gate_ctrl_if.sv
// Request/status bundle between the requesting domain and the gate controller.
interface clk_gate_ctrl_if;
    import clk_gate_pkg::*;

    logic               REQ;
    logic               BUSY;
    logic               FORCE_ON;
    logic               CLK_EN;
    logic               ACK;
    logic [STATE_W-1:0] STATE;

    modport master (
        output REQ, BUSY, FORCE_ON,
        input  CLK_EN, ACK, STATE
    );

    modport slave (
        input  REQ, BUSY, FORCE_ON,
        output CLK_EN, ACK, STATE
    );
endinterface

// File: rtl/gate_dncnt.sv
// Loadable down-counter shared by the wake settle and idle timeout phases.
// Saturates at 1 so it can never wrap; at_one is registered alongside the count.
module gate_dncnt #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             at_one
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // Next count: load has priority, decrement stops at 1.
    always_comb begin
        cnt_next = cnt;
        if (load) begin
            cnt_next = load_val;
        end else if (dec && (cnt > CNT_W'(1))) begin
            cnt_next = cnt - CNT_W'(1);
        end
    end

    // Count register and its at-one flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            at_one <= 1'b0;
        end else begin
            cnt    <= cnt_next;
            at_one <= (cnt_next == CNT_W'(1));
        end
    end

endmodule

// File: rtl/clk_gate_ctrl.sv
// Drives CLK_EN of the clock-gate cell: wakes on request, settles before ACK,
// and gates off after a programmable idle timeout.
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int unsigned WAKE_CNT = 2,
    parameter int unsigned IDLE_CNT = 4,
    parameter int unsigned CNT_W    = 4
) (
    input  logic           CLK,
    input  logic           RST,
    clk_gate_ctrl_if.slave bus
);

    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    // Reject zero or out-of-range counts at elaboration.
    if (CNT_W == 0 || WAKE_CNT == 0 || IDLE_CNT == 0 ||
        WAKE_CNT > CNT_MAX || IDLE_CNT > CNT_MAX) begin : g_bad_param
        $error("clk_gate_ctrl: WAKE_CNT/IDLE_CNT must be in 1..2^CNT_W-1 and CNT_W > 0");
    end

    state_t           state;
    logic             clk_en;
    logic             ack;
    logic             active;
    logic             wake_go;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             at_one;

    // Counter control derived from current state and request inputs.
    always_comb begin
        active       = bus.REQ | bus.BUSY | bus.FORCE_ON;
        wake_go      = bus.REQ | bus.FORCE_ON;
        cnt_load     = 1'b0;
        cnt_load_val = CNT_W'(IDLE_CNT);
        cnt_dec      = 1'b0;
        unique case (state)
            ST_OFF: begin
                cnt_load     = wake_go;
                cnt_load_val = CNT_W'(WAKE_CNT);
            end
            ST_WAKE: cnt_dec  = 1'b1;
            ST_ON:   cnt_load = ~active;
            ST_HOLD: cnt_dec  = ~active;
            default: ;
        endcase
    end

    gate_dncnt #(
        .CNT_W (CNT_W)
    ) u_dncnt (
        .clk      (CLK),
        .rst      (RST),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .at_one   (at_one)
    );

    // State machine with registered CLK_EN and ACK.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= ST_OFF;
            clk_en <= 1'b0;
            ack    <= 1'b0;
        end else begin
            unique case (state)
                ST_OFF: begin
                    ack <= 1'b0;
                    if (wake_go) begin
                        state  <= ST_WAKE;
                        clk_en <= 1'b1;
                    end else begin
                        clk_en <= 1'b0;
                    end
                end
                ST_WAKE: begin
                    clk_en <= 1'b1;
                    // Wake always completes, even if REQ dropped meanwhile.
                    if (at_one) begin
                        state <= ST_ON;
                        ack   <= bus.REQ;
                    end else begin
                        ack <= 1'b0;
                    end
                end
                ST_ON: begin
                    clk_en <= 1'b1;
                    if (!active) begin
                        state <= ST_HOLD;
                        ack   <= 1'b0;
                    end else begin
                        ack <= bus.REQ;
                    end
                end
                ST_HOLD: begin
                    // Activity beats idle expiry; clock is still running so no re-wake.
                    if (active) begin
                        state  <= ST_ON;
                        clk_en <= 1'b1;
                        ack    <= bus.REQ;
                    end else if (at_one) begin
                        state  <= ST_OFF;
                        clk_en <= 1'b0;
                        ack    <= 1'b0;
                    end else begin
                        clk_en <= 1'b1;
                        ack    <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_OFF;
                    clk_en <= 1'b0;
                    ack    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.CLK_EN = clk_en;
    assign bus.ACK    = ack;
    assign bus.STATE  = state;

endmodule
